// File: rtl/pilha_pkg.sv
// Shared types and constants for the pilha LIFO stack.
// Latency: none; this file holds declarations only.
// Backpressure: none; this file holds declarations only.
package pilha_pkg;

    // Default geometry used when the parent does not override it
    localparam int WIDTH_PADRAO = 8;
    localparam int DEPTH_PADRAO = 32;

    // Push source select carried on the controle input
    localparam logic CTRL_MEM = 1'b0;   // data_in: memory or immediate
    localparam logic CTRL_ULA = 1'b1;   // data_ula: ALU result

    // Pop sequencer: idle, or waiting one cycle for the RAM read to land
    typedef enum logic {
        OCIOSO  = 1'b0,
        LEITURA = 1'b1
    } estado_t;

endpackage

// File: rtl/pilha_if.sv
// Request/response bundle between a stack user (master) and pilha (slave).
// Latency: none; wiring only.
// Backpressure: ocupado tells the master that requests are being dropped.
interface pilha_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 32
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             wren;
    logic             rden;
    logic             controle;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_ula;
    logic [WIDTH-1:0] data_out;
    logic             valid_out;
    logic             ocupado;
    logic [WIDTH-1:0] topo;
    logic [CW-1:0]    contagem;
    logic             vazia;
    logic             cheia;
    logic             erro_overflow;
    logic             erro_underflow;

    modport master (
        output wren, rden, controle, data_in, data_ula,
        input  data_out, valid_out, ocupado, topo, contagem,
               vazia, cheia, erro_overflow, erro_underflow
    );

    modport slave (
        input  wren, rden, controle, data_in, data_ula,
        output data_out, valid_out, ocupado, topo, contagem,
               vazia, cheia, erro_overflow, erro_underflow
    );

endinterface

// File: rtl/pilha_mem.sv
// DEPTH x WIDTH stack storage: synchronous write, registered read, plus a peek port for the top word.
// Latency: write and registered read take effect at the clock edge; the peek port is combinational.
// Backpressure: none; the parent only issues legal accesses.
module pilha_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 32,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_dat,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_dat,
    input  logic [AW-1:0]    peek_addr,
    output logic [WIDTH-1:0] peek_dat
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port and registered read port; rd_dat holds between reads
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
        if (rd_en) begin
            rd_dat <= mem[rd_addr];
        end
    end

    // The top word must be visible without a cycle of delay
    assign peek_dat = mem[peek_addr];

endmodule

// File: rtl/pilha.sv
// LIFO stack with push, two-cycle pop, single-cycle replace; macro PILHA_ERRO_STICKY_EN makes error flags sticky.
// Latency: push visible on topo next cycle; pop data 2 cycles after rden; replace data 1 cycle after request.
// Backpressure: ocupado high during the pop read cycle, when requests are dropped; full/empty requests only flag errors.
module pilha
    import pilha_pkg::*;
#(
    parameter int WIDTH = WIDTH_PADRAO,
    parameter int DEPTH = DEPTH_PADRAO
) (
    input  logic   clock,
    input  logic   reset,
    pilha_if.slave bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    estado_t          estado, estado_prox;
    logic [CW-1:0]    sp;
    logic [WIDTH-1:0] data_out_q;
    logic             valid_q;
    logic             ovf_q, unf_q;

    logic             do_push, do_pop, do_repl;
    logic             ev_ovf, ev_unf;
    logic             vazia, cheia;
    logic [AW-1:0]    addr_topo;
    logic [WIDTH-1:0] dat_sel, rd_dat, peek_dat, topo;

    assign vazia     = (sp == '0);
    assign cheia     = (sp == CW'(DEPTH));
    assign addr_topo = AW'(sp - CW'(1));
    assign dat_sel   = (bus.controle == CTRL_ULA) ? bus.data_ula : bus.data_in;
    assign topo      = vazia ? '0 : peek_dat;

    // Memory is never written or read while reset is held, so reset wins over any request
    pilha_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clock     (clock),
        .wr_en     ((do_push || do_repl) && !reset),
        .wr_addr   (do_repl ? addr_topo : AW'(sp)),
        .wr_dat    (dat_sel),
        .rd_en     (do_pop && !reset),
        .rd_addr   (addr_topo),
        .rd_dat    (rd_dat),
        .peek_addr (addr_topo),
        .peek_dat  (peek_dat)
    );

    // FSM state register
    always_ff @(posedge clock) begin
        if (reset) begin
            estado <= OCIOSO;
        end else begin
            estado <= estado_prox;
        end
    end

    // Request decode: only OCIOSO accepts work; full/empty requests become error events
    always_comb begin
        estado_prox = estado;
        do_push     = 1'b0;
        do_pop      = 1'b0;
        do_repl     = 1'b0;
        ev_ovf      = 1'b0;
        ev_unf      = 1'b0;
        case (estado)
            OCIOSO: begin
                if (bus.wren && !bus.rden) begin
                    if (cheia) ev_ovf  = 1'b1;
                    else       do_push = 1'b1;
                end else if (bus.rden && !bus.wren) begin
                    if (vazia) begin
                        ev_unf = 1'b1;
                    end else begin
                        do_pop      = 1'b1;
                        estado_prox = LEITURA;
                    end
                end else if (bus.rden && bus.wren) begin
                    if (vazia) ev_unf  = 1'b1;
                    else       do_repl = 1'b1;
                end
            end
            LEITURA: begin
                estado_prox = OCIOSO;
            end
            default: begin
                estado_prox = OCIOSO;
            end
        endcase
    end

    // Stack pointer, popped data, valid pulse and error flags
    always_ff @(posedge clock) begin
        if (reset) begin
            sp         <= '0;
            data_out_q <= '0;
            valid_q    <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (do_push) begin
                sp <= sp + CW'(1);
            end
            if (do_pop) begin
                sp <= sp - CW'(1);
            end
            if (do_repl) begin
                data_out_q <= topo;
                valid_q    <= 1'b1;
            end
            if (estado == LEITURA) begin
                data_out_q <= rd_dat;
                valid_q    <= 1'b1;
            end
`ifdef PILHA_ERRO_STICKY_EN
            ovf_q <= ovf_q | ev_ovf;
            unf_q <= unf_q | ev_unf;
`else
            ovf_q <= ev_ovf;
            unf_q <= ev_unf;
`endif
        end
    end

    assign bus.data_out       = data_out_q;
    assign bus.valid_out      = valid_q;
    assign bus.ocupado        = (estado == LEITURA);
    assign bus.topo           = topo;
    assign bus.contagem       = sp;
    assign bus.vazia          = vazia;
    assign bus.cheia          = cheia;
    assign bus.erro_overflow  = ovf_q;
    assign bus.erro_underflow = unf_q;

endmodule

// File: doc/pilha.md
PILHA -- requirements
Module: pilha

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 32, number of stack entries (power of two).
REQ-003 SHALL have port clock  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port wren  input  1  push request.
REQ-006 SHALL have port rden  input  1  pop request.
REQ-007 SHALL have port controle  input  1  push source: 0 = data_in, 1 = data_ula.
REQ-008 SHALL have port data_in  input  WIDTH  push data from memory or immediate.
REQ-009 SHALL have port data_ula  input  WIDTH  push data from ALU result.
REQ-010 SHALL have port data_out  output  WIDTH  popped word, held until the next pop completes.
REQ-011 SHALL have port valid_out  output  1  one-cycle pulse when data_out is updated.
REQ-012 SHALL have port ocupado  output  1  high while a pop is in flight; requests are ignored then.
REQ-013 SHALL have port topo  output  WIDTH  current top-of-stack word; 0 when empty.
REQ-014 SHALL have port contagem  output  log2(DEPTH)+1  occupancy, 0..DEPTH.
REQ-015 SHALL have ports vazia, cheia  output  1 each  contagem == 0 and contagem == DEPTH, respectively.
REQ-016 SHALL have ports erro_overflow, erro_underflow  output  1 each  error indications.

Function
REQ-017 SHALL implement a two-state FSM with states OCIOSO and LEITURA.
REQ-018 In OCIOSO, with wren=1 and rden=0 and not cheia, SHALL write the selected source to mem[sp] and increment sp, with effect visible on topo and contagem in the next cycle.
REQ-019 In OCIOSO, with rden=1 and wren=0 and not vazia, SHALL decrement sp, go to LEITURA, and assert ocupado.
REQ-020 In LEITURA, SHALL register mem[sp] into data_out, pulse valid_out for exactly one cycle, and return to OCIOSO; pop latency from rden to valid_out is 2 cycles.
REQ-021 In OCIOSO, with wren=1 and rden=1 and not vazia, SHALL perform a replace: data_out receives the old top and valid_out pulses on the next cycle, the new word is written at sp-1, sp is unchanged, and the FSM stays in OCIOSO.
REQ-022 For push while cheia, SHALL leave memory and sp unchanged and flag erro_overflow.
REQ-023 For pop or replace while vazia, SHALL leave memory, sp and data_out unchanged, not pulse valid_out, and flag erro_underflow.
REQ-024 Requests in LEITURA SHALL be dropped without side effects and SHALL NOT flag errors.
REQ-025 sp SHALL never wrap; contagem SHALL saturate at 0 and DEPTH.
REQ-026 The topo output SHALL be combinational from mem[sp-1] when contagem > 0.

Reset
REQ-027 While reset=1, SHALL set sp=0, FSM=OCIOSO, data_out=0, valid_out=0, ocupado=0, and both error flags to 0; memory contents are don't-care.
REQ-028 Reset asserted in LEITURA SHALL abort the pop with no valid_out pulse.
REQ-029 Reset SHALL take priority over any simultaneous request.

Configuration
REQ-030 With PILHA_ERRO_STICKY_EN defined, error flags SHALL latch high until reset.
REQ-031 Without PILHA_ERRO_STICKY_EN, each error flag SHALL be a one-cycle pulse in the cycle after the offending request.

Structure
REQ-032 A shared package SHALL hold the FSM state enum (OCIOSO, LEITURA), the controle source encodings, and the default WIDTH/DEPTH constants.
REQ-033 One sub-module, pilha_mem (synchronous-write, registered-read RAM, DEPTH x WIDTH), SHALL be instantiated.

Verification
REQ-034 Reset, then push 0x11, 0x22, 0x33 with controle=0 -> contagem=3, topo=0x33.
REQ-035 Pop with the stack holding 0x11, 0x22, 0x33 -> valid_out 2 cycles after rden, data_out=0x33, topo=0x22; a request in the cycle after rden is ignored.
REQ-036 Push 0x5A with controle=1 (data_ula=0x5A, data_in=0xFF) -> topo=0x5A.
REQ-037 Fill to 32 entries and push again -> cheia=1, erro_overflow asserted, topo unchanged; with the stack empty, pop -> erro_underflow asserted, no valid_out.
REQ-038 Replace with wren=rden=1 on stack {0x01, 0x02} and data_in=0x09 -> data_out=0x02, topo=0x09, contagem=2.
REQ-039 Assert reset during LEITURA -> no valid_out, contagem=0; error flag behaviour checked both with and without PILHA_ERRO_STICKY_EN.
